// File: rtl/aftab_mem_arbiter.sv
// Three-requester round-robin memory bus arbiter (write unit, read unit, fetch)
// with per-access timeout abort.
module aftab_mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqDAWU,
    input  logic        reqDARU,
    input  logic        reqIF,
    input  logic [31:0] addrDAWU,
    input  logic [31:0] addrDARU,
    input  logic [31:0] addrIF,
    input  logic [7:0]  dataDAWU,
    input  logic        memRdy,
    input  logic [7:0]  memDataIn,
    output logic [31:0] memAddr,
    output logic [7:0]  memDataOut,
    output logic        readMem,
    output logic        writeMem,
    output logic        grantDAWU,
    output logic        grantDARU,
    output logic        grantIF,
    output logic        rdyDAWU,
    output logic        rdyDARU,
    output logic        rdyIF,
    output logic        errDAWU,
    output logic        errDARU,
    output logic        errIF,
    output logic [7:0]  dataRd,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;   // bit 0 = DAWU, 1 = DARU, 2 = IF
    logic [1:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        first_q, first_d;   // marks the first ABORT cycle for the err pulse

    logic [2:0]  req_v;
    logic        owner_req;
    logic        active;
    logic [1:0]  i0, i1, i2, sel_idx;
    logic        sel_vld;

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign req_v     = {reqIF, reqDARU, reqDAWU};
    assign owner_req = |(grant_q & req_v);
    assign i0        = nxt(last_q);
    assign i1        = nxt(i0);
    assign i2        = nxt(i1);

    always_comb begin
        sel_vld = 1'b1;
        sel_idx = i0;
        if (req_v[i0])      sel_idx = i0;
        else if (req_v[i1]) sel_idx = i1;
        else if (req_v[i2]) sel_idx = i2;
        else                sel_vld = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            last_q  <= 2'd1;
            cnt_q   <= 8'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (sel_vld) begin
                    state_d = BUSY;
                    grant_d = 3'b001 << sel_idx;
                    last_d  = sel_idx;
                end
            end
            BUSY: begin
                // Owner release wins over both completion and timeout.
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                    cnt_d   = 8'd0;
                end else if (memRdy) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    state_d = ABORT;
                    first_d = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ABORT: begin
                cnt_d = 8'd0;
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        active     = (state_q == BUSY) && owner_req;
        memAddr    = 32'd0;
        if (state_q == BUSY) begin
            unique case (grant_q)
                3'b001:  memAddr = addrDAWU;
                3'b010:  memAddr = addrDARU;
                3'b100:  memAddr = addrIF;
                default: memAddr = 32'd0;
            endcase
        end
        writeMem   = active && grant_q[0];
        readMem    = active && (grant_q[1] || grant_q[2]);
        {rdyIF, rdyDARU, rdyDAWU} = active ? (grant_q & {3{memRdy}}) : 3'b000;
        {errIF, errDARU, errDAWU} = (state_q == ABORT && first_q) ? grant_q : 3'b000;
        {grantIF, grantDARU, grantDAWU} = grant_q;
        memDataOut = (state_q == BUSY && grant_q[0]) ? dataDAWU : 8'd0;
        busy       = (state_q != IDLE);
        dataRd     = memDataIn;
    end
endmodule

// File: tb/tb_aftab_mem_arbiter.sv
// Scoreboard bench for aftab_mem_arbiter (TIMEOUT = 4): the driver pushes the
// hand-derived expected outputs per cycle, a negedge monitor pops and compares.
module tb_aftab_mem_arbiter;
    localparam logic [31:0] A_W = 32'h1000_0040;
    localparam logic [31:0] A_R = 32'h2000_0080;
    localparam logic [31:0] A_I = 32'h3000_00C0;
    localparam logic [7:0]  DW  = 8'hA5;

    logic        clk = 1'b0, rst = 1'b1;
    logic        reqDAWU = 0, reqDARU = 0, reqIF = 0, memRdy = 0;
    logic [31:0] addrDAWU = A_W, addrDARU = A_R, addrIF = A_I;
    logic [7:0]  dataDAWU = DW, memDataIn = 8'h00;
    logic [31:0] memAddr;
    logic [7:0]  memDataOut, dataRd;
    logic        readMem, writeMem, grantDAWU, grantDARU, grantIF;
    logic        rdyDAWU, rdyDARU, rdyIF, errDAWU, errDARU, errIF, busy;

    typedef struct packed {
        logic [2:0]  g;
        logic [2:0]  rdy;
        logic [2:0]  err;
        logic        rd;
        logic        wr;
        logic        bsy;
        logic [31:0] addr;
        logic [7:0]  dout;
        logic [7:0]  drd;
    } vec_t;

    vec_t  exp_q[$];
    string nm_q[$];
    int    n_vec = 0, n_bad = 0;

    aftab_mem_arbiter #(.TIMEOUT(8'd4)) dut (
        .clk(clk), .rst(rst),
        .reqDAWU(reqDAWU), .reqDARU(reqDARU), .reqIF(reqIF),
        .addrDAWU(addrDAWU), .addrDARU(addrDARU), .addrIF(addrIF),
        .dataDAWU(dataDAWU), .memRdy(memRdy), .memDataIn(memDataIn),
        .memAddr(memAddr), .memDataOut(memDataOut),
        .readMem(readMem), .writeMem(writeMem),
        .grantDAWU(grantDAWU), .grantDARU(grantDARU), .grantIF(grantIF),
        .rdyDAWU(rdyDAWU), .rdyDARU(rdyDARU), .rdyIF(rdyIF),
        .errDAWU(errDAWU), .errDARU(errDARU), .errIF(errIF),
        .dataRd(dataRd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: compares whatever the driver queued for the current cycle.
    always @(negedge clk) begin
        vec_t  e, a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a.g    = {grantIF, grantDARU, grantDAWU};
            a.rdy  = {rdyIF, rdyDARU, rdyDAWU};
            a.err  = {errIF, errDARU, errDAWU};
            a.rd   = readMem;
            a.wr   = writeMem;
            a.bsy  = busy;
            a.addr = memAddr;
            a.dout = memDataOut;
            a.drd  = dataRd;
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got g=%b rdy=%b err=%b rd=%b wr=%b busy=%b addr=%h dout=%h drd=%h, want g=%b rdy=%b err=%b rd=%b wr=%b busy=%b addr=%h dout=%h drd=%h",
                         nm, a.g, a.rdy, a.err, a.rd, a.wr, a.bsy, a.addr, a.dout, a.drd,
                         e.g, e.rdy, e.err, e.rd, e.wr, e.bsy, e.addr, e.dout, e.drd);
            end
        end
    end

    // One cycle: drive {IF,DARU,DAWU} requests and memRdy just after the edge,
    // queue the outputs expected for the rest of that cycle.
    task automatic cyc(input logic r, input logic [2:0] req, input logic m,
                       input logic [2:0] g, input logic [2:0] rdy, input logic [2:0] err,
                       input logic rd, input logic wr, input logic bsy,
                       input logic [31:0] addr, input logic [7:0] dout, input string nm);
        vec_t e;
        @(posedge clk);
        #1;
        rst = r;
        {reqIF, reqDARU, reqDAWU} = req;
        memRdy = m;
        memDataIn = memDataIn + 8'h1B;
        e = '{g: g, rdy: rdy, err: err, rd: rd, wr: wr, bsy: bsy,
              addr: addr, dout: dout, drd: memDataIn};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic idle(input logic r, input logic [2:0] req, input logic m, input string nm);
        cyc(r, req, m, 3'b000, 3'b000, 3'b000, 0, 0, 0, 32'd0, 8'd0, nm);
    endtask

    initial begin
        // Reset with all requests high, then IF wins first.
        idle(1, 3'b111, 0, "reset_hold");
        idle(0, 3'b111, 0, "reset_release");
        cyc(0, 3'b111, 0, 3'b100, 3'b000, 3'b000, 1, 0, 1, A_I, 8'd0, "if_grant");
        cyc(0, 3'b111, 1, 3'b100, 3'b100, 3'b000, 1, 0, 1, A_I, 8'd0, "if_rdy");
        cyc(0, 3'b011, 0, 3'b100, 3'b000, 3'b000, 0, 0, 1, A_I, 8'd0, "if_release");
        idle(0, 3'b011, 0, "idle_gap1");
        // DAWU 4-byte write, DARU waiting throughout.
        cyc(0, 3'b011, 0, 3'b001, 3'b000, 3'b000, 0, 1, 1, A_W, DW, "dawu_grant");
        cyc(0, 3'b011, 1, 3'b001, 3'b001, 3'b000, 0, 1, 1, A_W, DW, "dawu_b1");
        cyc(0, 3'b011, 0, 3'b001, 3'b000, 3'b000, 0, 1, 1, A_W, DW, "dawu_wait");
        cyc(0, 3'b011, 1, 3'b001, 3'b001, 3'b000, 0, 1, 1, A_W, DW, "dawu_b2");
        cyc(0, 3'b011, 1, 3'b001, 3'b001, 3'b000, 0, 1, 1, A_W, DW, "dawu_b3");
        cyc(0, 3'b011, 0, 3'b001, 3'b000, 3'b000, 0, 1, 1, A_W, DW, "dawu_wait2");
        cyc(0, 3'b011, 1, 3'b001, 3'b001, 3'b000, 0, 1, 1, A_W, DW, "dawu_b4");
        cyc(0, 3'b010, 1, 3'b001, 3'b000, 3'b000, 0, 0, 1, A_W, DW, "dawu_release_rdy_masked");
        idle(0, 3'b010, 0, "idle_gap2");
        // DARU times out after 4 BUSY cycles.
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru_to_c1");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru_to_c2");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru_to_c3");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru_to_c4");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b010, 0, 0, 1, 32'd0, 8'd0, "abort_err");
        cyc(0, 3'b010, 1, 3'b010, 3'b000, 3'b000, 0, 0, 1, 32'd0, 8'd0, "abort_hold_rdy_ignored");
        cyc(0, 3'b000, 0, 3'b010, 3'b000, 3'b000, 0, 0, 1, 32'd0, 8'd0, "abort_req_drop");
        idle(0, 3'b000, 0, "abort_exit");
        // memRdy in the 4th BUSY cycle completes normally.
        idle(0, 3'b010, 0, "daru2_sample");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru2_c1");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru2_c2");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru2_c3");
        cyc(0, 3'b010, 1, 3'b010, 3'b010, 3'b000, 1, 0, 1, A_R, 8'd0, "daru2_c4_rdy");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru2_no_abort1");
        cyc(0, 3'b010, 0, 3'b010, 3'b000, 3'b000, 1, 0, 1, A_R, 8'd0, "daru2_no_abort2");
        cyc(0, 3'b000, 0, 3'b010, 3'b000, 3'b000, 0, 0, 1, A_R, 8'd0, "daru2_release");
        idle(0, 3'b000, 0, "idle_gap3");
        // Round robin with all three held: IF, DAWU, DARU, IF.
        idle(0, 3'b111, 0, "rr_sample");
        cyc(0, 3'b111, 1, 3'b100, 3'b100, 3'b000, 1, 0, 1, A_I, 8'd0, "rr_if");
        cyc(0, 3'b011, 0, 3'b100, 3'b000, 3'b000, 0, 0, 1, A_I, 8'd0, "rr_if_rel");
        idle(0, 3'b111, 0, "rr_gap1");
        cyc(0, 3'b111, 1, 3'b001, 3'b001, 3'b000, 0, 1, 1, A_W, DW, "rr_dawu");
        cyc(0, 3'b110, 0, 3'b001, 3'b000, 3'b000, 0, 0, 1, A_W, DW, "rr_dawu_rel");
        idle(0, 3'b111, 0, "rr_gap2");
        cyc(0, 3'b111, 1, 3'b010, 3'b010, 3'b000, 1, 0, 1, A_R, 8'd0, "rr_daru");
        cyc(0, 3'b101, 0, 3'b010, 3'b000, 3'b000, 0, 0, 1, A_R, 8'd0, "rr_daru_rel");
        idle(0, 3'b111, 0, "rr_gap3");
        cyc(0, 3'b111, 0, 3'b100, 3'b000, 3'b000, 1, 0, 1, A_I, 8'd0, "rr_if2");
        cyc(0, 3'b011, 0, 3'b100, 3'b000, 3'b000, 0, 0, 1, A_I, 8'd0, "rr_if2_rel");
        idle(0, 3'b001, 0, "rr_gap4");
        // Reset mid-write with IF pending.
        cyc(0, 3'b101, 0, 3'b001, 3'b000, 3'b000, 0, 1, 1, A_W, DW, "wr_before_rst");
        idle(1, 3'b101, 0, "rst_mid_write");
        idle(0, 3'b101, 0, "rst_release2");
        cyc(0, 3'b101, 0, 3'b100, 3'b000, 3'b000, 1, 0, 1, A_I, 8'd0, "if_after_rst");
        cyc(0, 3'b000, 0, 3'b100, 3'b000, 3'b000, 0, 0, 1, A_I, 8'd0, "if_after_rst_rel");
        idle(0, 3'b000, 0, "final_idle");
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want run complete");
        $fatal(1, "watchdog");
    end
endmodule
